// File: rtl/spart_rx.sv
// SPART receive stage: 2-flop input synchroniser, oversampled start/data/stop FSM and bus read handshake.
// Optional build macro SPART_RX_MAJORITY_EN: each sample is a 2-of-3 vote over three consecutive ticks.
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 baud_tick,
    input  logic                 receive_read_en,
    output logic [DATA_BITS-1:0] receive_read_line,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   armed_q;
    logic                   rxd_meta_q;
    logic                   rxd_s_q;
    logic [1:0]             fill_q;
    logic                   sample_d;

    // fill_q keeps the reset value of the synchroniser from arming the receiver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            fill_q     <= 2'b00;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            fill_q     <= {fill_q[0], 1'b1};
        end
    end

`ifdef SPART_RX_MAJORITY_EN
    // Vote over the current and two previous ticks; START decides one tick late, so DATA reloads at 1 to keep phase.
    localparam logic [CW-1:0] START_HIT   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] DATA_RELOAD = CW'(1);
    logic [1:0] vote_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 2'b11;
        end else if (baud_tick) begin
            vote_q <= {vote_q[0], rxd_s_q};
        end
    end

    assign sample_d = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s_q) | (vote_q[0] & rxd_s_q);
`else
    localparam logic [CW-1:0] START_HIT   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] DATA_RELOAD = CW'(0);

    assign sample_d = rxd_s_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            bit_q             <= '0;
            shift_q           <= '0;
            armed_q           <= 1'b0;
            receive_read_line <= '0;
            rda               <= 1'b0;
            framing_err       <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            if (receive_read_en) begin
                framing_err <= 1'b0;
                if (rda) begin
                    rda     <= 1'b0;
                    overrun <= 1'b0;
                end
            end
            if (baud_tick) begin
                cnt_q <= cnt_q + 1'b1;
                unique case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (rxd_s_q && fill_q[1]) armed_q <= 1'b1;
                        if (armed_q && !rxd_s_q) state_q <= START;
                    end
                    START: begin
                        if (cnt_q == START_HIT) begin
                            if (sample_d) begin
                                state_q <= IDLE;
                            end else begin
                                cnt_q   <= DATA_RELOAD;
                                bit_q   <= '0;
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt_q == LAST_TICK) begin
                            cnt_q   <= '0;
                            shift_q <= {sample_d, shift_q[DATA_BITS-1:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == BW'(DATA_BITS - 1)) state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (cnt_q == LAST_TICK) begin
                            state_q <= IDLE;
                            if (sample_d) begin
                                // A read landing on this cycle consumes the old byte, so no overrun.
                                receive_read_line <= shift_q;
                                rda               <= 1'b1;
                                framing_err       <= 1'b0;
                                overrun           <= receive_read_en ? 1'b0 : (overrun | rda);
                            end else begin
                                framing_err <= 1'b1;
                                armed_q     <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames are driven bit by bit and every result is checked against hand-computed values.
module tb_spart_rx;
    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          baud_tick = 1'b0;
    logic          receive_read_en = 1'b0;
    logic [DB-1:0] receive_read_line;
    logic          rda;
    logic          framing_err;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    int tick_div = 1;
    int phase = 0;
    int lat;
    logic [7:0] glitch_exp;

    spart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rxd               (rxd),
        .baud_tick         (baud_tick),
        .receive_read_en   (receive_read_en),
        .receive_read_line (receive_read_line),
        .rda               (rda),
        .framing_err       (framing_err),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            phase++;
            baud_tick = ((phase % tick_div) == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // glitch_bit selects a data bit to invert for one clock at its centre; 99 means none.
    task automatic send(input logic [7:0] data, input logic stop, input int glitch_bit,
                        input bit read_on_stop, output int rda_at);
        logic [9:0] frame;
        frame  = {stop, data, 1'b0};
        rda_at = -1;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < OS * tick_div; c++) begin
                rxd = frame[k];
                if (k == glitch_bit + 1 && c == OS / 2) rxd = ~frame[k];
                receive_read_en = read_on_stop && (k == 9) && (c == 10);
                if (rda_at < 0 && rda === 1'b1) rda_at = k * OS * tick_div + c;
                step(1);
            end
        end
        receive_read_en = 1'b0;
        rxd = 1'b1;
        step(8);
        $display("frame data=%02h stop=%0b -> line=%02h rda=%0b ferr=%0b ovr=%0b",
                 data, stop, receive_read_line, rda, framing_err, overrun);
    endtask

    task automatic read_pulse();
        receive_read_en = 1'b1;
        step(1);
        receive_read_en = 1'b0;
    endtask

    initial begin
`ifdef SPART_RX_MAJORITY_EN
        glitch_exp = 8'hFF;
`else
        glitch_exp = 8'hF7;
`endif
        step(3);
        chk("reset_line", receive_read_line, 0);
        chk("reset_rda", rda, 0);
        chk("reset_ferr", framing_err, 0);
        chk("reset_ovr", overrun, 0);
        rst_n = 1'b1;
        step(5);

        send(8'hA5, 1'b1, 99, 1'b0, lat);
        $display("latency from start edge = %0d clk", lat);
        chk("latency_in_window", (lat >= 152 && lat <= 156), 1);
        chk("a5_rda", rda, 1);
        chk("a5_line", receive_read_line, 8'hA5);
        chk("a5_ferr", framing_err, 0);
        chk("a5_ovr", overrun, 0);
        read_pulse();
        chk("a5_read_rda", rda, 0);
        chk("a5_read_line", receive_read_line, 8'hA5);

        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        step(40);
        $display("glitch pulse -> rda=%0b ferr=%0b", rda, framing_err);
        chk("glitch_rda", rda, 0);
        chk("glitch_ferr", framing_err, 0);
        send(8'h3C, 1'b1, 99, 1'b0, lat);
        chk("3c_line", receive_read_line, 8'h3C);
        chk("3c_rda", rda, 1);
        read_pulse();

        send(8'h81, 1'b0, 99, 1'b0, lat);
        chk("bad_stop_ferr", framing_err, 1);
        chk("bad_stop_rda", rda, 0);
        chk("bad_stop_line", receive_read_line, 8'h3C);
        send(8'h42, 1'b1, 99, 1'b0, lat);
        chk("42_ferr", framing_err, 0);
        chk("42_line", receive_read_line, 8'h42);
        chk("42_rda", rda, 1);
        read_pulse();
        chk("42_read_rda", rda, 0);

        send(8'h11, 1'b1, 99, 1'b0, lat);
        chk("11_ovr", overrun, 0);
        send(8'h22, 1'b1, 99, 1'b0, lat);
        chk("ovr_line", receive_read_line, 8'h22);
        chk("ovr_rda", rda, 1);
        chk("ovr_flag", overrun, 1);
        read_pulse();
        chk("ovr_read_rda", rda, 0);
        chk("ovr_read_flag", overrun, 0);

        send(8'h11, 1'b1, 99, 1'b0, lat);
        chk("11b_rda", rda, 1);
        send(8'h22, 1'b1, 99, 1'b1, lat);
        chk("same_cycle_rda", rda, 1);
        chk("same_cycle_ovr", overrun, 0);
        chk("same_cycle_line", receive_read_line, 8'h22);
        read_pulse();

        send(8'hFF, 1'b1, 3, 1'b0, lat);
        chk("midbit_glitch_line", receive_read_line, glitch_exp);
        read_pulse();

        tick_div = 2;
        send(8'h96, 1'b1, 99, 1'b0, lat);
        chk("div2_line", receive_read_line, 8'h96);
        chk("div2_rda", rda, 1);
        tick_div = 1;
        step(2);

        rxd = 1'b0;
        step(40);
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-frame -> line=%02h rda=%0b ferr=%0b ovr=%0b",
                 receive_read_line, rda, framing_err, overrun);
        chk("async_rst_line", receive_read_line, 0);
        chk("async_rst_rda", rda, 0);
        chk("async_rst_ferr", framing_err, 0);
        chk("async_rst_ovr", overrun, 0);
        rxd = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(20);
        send(8'h5A, 1'b1, 99, 1'b0, lat);
        chk("5a_rda", rda, 1);
        chk("5a_line", receive_read_line, 8'h5A);
        chk("5a_ferr", framing_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
